// File: rtl/mc_controller.sv
// Multicycle sequencing controller: main FSM, datapath select decode, NZCV flags and condition gating.
// Optional: define MC_COND_EXEC_EN for full ARM condition-code evaluation (otherwise every instruction executes).
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  Flags
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t state, state_n;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd15;
  logic       cond_ok, cond_q;
  logic [1:0] alu_dec;
  logic       nowrite_dec, cv_upd, flag_ok, nowrite;
  logic       regw, memw, branch, aluop;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd15  = (Instr[15:12] == 4'hF);

  // ALU function decode; "other" codes execute as ADD but write neither Rd nor flags
  always_comb begin
    alu_dec     = 2'b00;
    nowrite_dec = 1'b0;
    cv_upd      = 1'b0;
    flag_ok     = 1'b1;
    case (funct[4:1])
      4'b0100: cv_upd = 1'b1;
      4'b0010: begin alu_dec = 2'b01; cv_upd = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin alu_dec = 2'b01; cv_upd = 1'b1; nowrite_dec = 1'b1; end
      default: begin nowrite_dec = 1'b1; flag_ok = 1'b0; end
    endcase
  end

  // NoWrite only concerns data-processing; memory ops reuse Funct bits as P/U/B/W/L
  assign nowrite = (op == 2'b00) & nowrite_dec;

`ifdef MC_COND_EXEC_EN
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = Flags[2];
      4'b0001: cond_ok = ~Flags[2];
      4'b0010: cond_ok = Flags[1];
      4'b0011: cond_ok = ~Flags[1];
      4'b0100: cond_ok = Flags[3];
      4'b0101: cond_ok = ~Flags[3];
      4'b0110: cond_ok = Flags[0];
      4'b0111: cond_ok = ~Flags[0];
      4'b1000: cond_ok = Flags[1] & ~Flags[2];
      4'b1001: cond_ok = ~Flags[1] | Flags[2];
      4'b1010: cond_ok = (Flags[3] == Flags[0]);
      4'b1011: cond_ok = (Flags[3] != Flags[0]);
      4'b1100: cond_ok = ~Flags[2] & (Flags[3] == Flags[0]);
      4'b1101: cond_ok = Flags[2] | (Flags[3] != Flags[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};
`else
  assign cond_ok = 1'b1;
  logic unused_instr;
  assign unused_instr = ^{cond, Instr[19:16], Instr[11:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      Flags  <= '0;
      cond_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE)
        cond_q <= cond_ok;
      if ((state == EXECUTER || state == EXECUTEI) && cond_q && funct[0] && flag_ok) begin
        Flags[3:2] <= ALUFlags[3:2];
        if (cv_upd)
          Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_n   = FETCH;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    case (state)
      FETCH: begin
        state_n = DECODE; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; IRWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (op)
          2'b01:   state_n = MEMADR;
          2'b00:   state_n = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_n = BRANCH;
          default: state_n = FETCH;
        endcase
      end
      MEMADR:   begin state_n = funct[0] ? MEMREAD : MEMWRITE; ALUSrcB = 2'b01; end
      MEMREAD:  begin state_n = MEMWB; AdrSrc = 1'b1; end
      MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; end
      EXECUTER: begin state_n = ALUWB; aluop = 1'b1; end
      EXECUTEI: begin state_n = ALUWB; ALUSrcB = 2'b01; aluop = 1'b1; end
      ALUWB:    regw = 1'b1;
      BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default:  state_n = FETCH;
    endcase

    ALUControl = aluop ? alu_dec : 2'b00;
    ImmSrc     = op;
    RegSrc     = {op == 2'b01, op == 2'b10};
    RegWrite   = regw & cond_q & ~nowrite;
    MemWrite   = memw & cond_q;
    PCWrite    = (state == FETCH) | (branch & cond_q)
               | ((state == ALUWB) & rd15 & cond_q & ~nowrite)
               | ((state == MEMWB) & rd15 & cond_q);

    // Reset can arrive in any state: suppress all writes and present fetch selects
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b10;
      ALUSrcA    = 1'b1;
      ALUSrcB    = 2'b10;
      ALUControl = 2'b00;
    end
  end

endmodule
